// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an async FIFO: Gray read pointer, occupancy and empty/almost-empty flags.
// Latency: one cycle from rd_en/wptr_sync to all registered outputs; reads while empty are dropped and flagged.
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AEMPTY_TH  = 1
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic                  clr_err,
  input  logic [ADDR_WIDTH:0]   wptr_sync,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  underflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_TH);

  logic [PW-1:0] r_rbin;
  logic [PW-1:0] r_rgray;
  logic          r_empty;
  logic          r_aempty;
  logic [PW-1:0] r_count;
  logic          r_underflow;

  logic          w_fire;
  logic [PW-1:0] w_rbin_next;
  logic [PW-1:0] w_rgray_next;
  logic [PW-1:0] w_wbin;
  logic [PW-1:0] w_count_next;
  logic          w_empty_next;
  logic          w_aempty_next;
  logic          w_underflow_next;

  assign w_fire       = rd_en & ~r_empty;
  assign w_rbin_next  = r_rbin + {{ADDR_WIDTH{1'b0}}, w_fire};
  assign w_rgray_next = w_rbin_next ^ (w_rbin_next >> 1);

  // Gray to binary: each bit is the XOR of itself and every more-significant Gray bit.
  always_comb begin
    w_wbin = '0;
    for (int i = 0; i < PW; i++) begin
      w_wbin[i] = ^(wptr_sync >> i);
    end
  end

  // Flags are computed from the post-read pointer so the last read and a
  // concurrent write are both reflected on the same edge.
  assign w_count_next     = w_wbin - w_rbin_next;
  assign w_empty_next     = (w_rgray_next == wptr_sync);
  assign w_aempty_next    = (w_count_next <= AE_TH);
  assign w_underflow_next = (r_underflow & ~clr_err) | (rd_en & r_empty);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_rbin      <= '0;
      r_rgray     <= '0;
      r_empty     <= 1'b1;
      r_aempty    <= 1'b1;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_rbin      <= w_rbin_next;
      r_rgray     <= w_rgray_next;
      r_empty     <= w_empty_next;
      r_aempty    <= w_aempty_next;
      r_count     <= w_count_next;
      r_underflow <= w_underflow_next;
    end
  end

  assign rd_addr      = r_rbin[ADDR_WIDTH-1:0];
  assign mem_rd_en    = w_fire;
  assign rptr_gray    = r_rgray;
  assign empty        = r_empty;
  assign almost_empty = r_aempty;
  assign rd_count     = r_count;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl (ADDR_WIDTH=3, AEMPTY_TH=1): vector tables, a wrap loop and async reset checks.
module tb_fifo_rd_ctrl;

  typedef struct {
    logic       rd_en;
    logic       clr;
    logic [3:0] wptr;
    logic [2:0] exp_addr;   // before the edge
    logic       exp_mrd;    // before the edge
    logic       exp_empty;  // after the edge
    logic       exp_ae;
    logic [3:0] exp_cnt;
    logic       exp_uf;
    logic [3:0] exp_gray;
  } vec_t;

  logic       CLK;
  logic       rst_n;
  logic       rd_en;
  logic       clr_err;
  logic [3:0] wptr_sync;
  logic [2:0] rd_addr;
  logic       mem_rd_en;
  logic [3:0] rptr_gray;
  logic       empty;
  logic       almost_empty;
  logic [3:0] rd_count;
  logic       underflow;

  logic clk_en;
  int   total;
  int   bad;
  vec_t exp_q[$];

  fifo_rd_ctrl #(.ADDR_WIDTH(3), .AEMPTY_TH(1)) dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .rd_en        (rd_en),
    .clr_err      (clr_err),
    .wptr_sync    (wptr_sync),
    .rd_addr      (rd_addr),
    .mem_rd_en    (mem_rd_en),
    .rptr_gray    (rptr_gray),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_count     (rd_count),
    .underflow    (underflow)
  );

  initial begin
    CLK = 1'b0;
    wait (clk_en);
    forever #5 CLK = ~CLK;
  end

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rd_addr"},      32'(rd_addr),      32'd0);
    chk({tag, "_mem_rd_en"},    32'(mem_rd_en),    32'd0);
    chk({tag, "_rptr_gray"},    32'(rptr_gray),    32'd0);
    chk({tag, "_empty"},        32'(empty),        32'd1);
    chk({tag, "_almost_empty"}, 32'(almost_empty), 32'd1);
    chk({tag, "_rd_count"},     32'(rd_count),     32'd0);
    chk({tag, "_underflow"},    32'(underflow),    32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    vec_t e;
    @(negedge CLK);
    rd_en     = v.rd_en;
    clr_err   = v.clr;
    wptr_sync = v.wptr;
    exp_q.push_back(v);
    #1;
    chk({tag, "_rd_addr"},   32'(rd_addr),   32'(v.exp_addr));
    chk({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'(v.exp_mrd));
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    chk({tag, "_empty"},        32'(empty),        32'(e.exp_empty));
    chk({tag, "_almost_empty"}, 32'(almost_empty), 32'(e.exp_ae));
    chk({tag, "_rd_count"},     32'(rd_count),     32'(e.exp_cnt));
    chk({tag, "_underflow"},    32'(underflow),    32'(e.exp_uf));
    chk({tag, "_rptr_gray"},    32'(rptr_gray),    32'(e.exp_gray));
  endtask

  vec_t tab_a[12];
  vec_t tab_b[3];
  vec_t w;

  initial begin
    total     = 0;
    bad       = 0;
    clk_en    = 1'b0;
    rst_n     = 1'b1;
    rd_en     = 1'b0;
    clr_err   = 1'b0;
    wptr_sync = 4'b0000;

    //          rd  clr wptr     addr mrd emp ae  cnt     uf  gray
    tab_a[0]  = '{1'b0, 1'b0, 4'b0010, 3'd0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 4'b0000};
    tab_a[1]  = '{1'b1, 1'b0, 4'b0010, 3'd0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 4'b0001};
    tab_a[2]  = '{1'b1, 1'b0, 4'b0010, 3'd1, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 4'b0011};
    tab_a[3]  = '{1'b1, 1'b0, 4'b0010, 3'd2, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0010};
    tab_a[4]  = '{1'b1, 1'b0, 4'b0010, 3'd3, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 4'b0010};
    tab_a[5]  = '{1'b0, 1'b0, 4'b0010, 3'd3, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 4'b0010};
    tab_a[6]  = '{1'b0, 1'b1, 4'b0010, 3'd3, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0010};
    tab_a[7]  = '{1'b1, 1'b1, 4'b0010, 3'd3, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 4'b0010};
    tab_a[8]  = '{1'b0, 1'b1, 4'b0010, 3'd3, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0010};
    tab_a[9]  = '{1'b0, 1'b0, 4'b0110, 3'd3, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 4'b0010};
    tab_a[10] = '{1'b1, 1'b0, 4'b0111, 3'd3, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 4'b0110};
    tab_a[11] = '{1'b0, 1'b0, 4'b1010, 3'd4, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 4'b0110};

    tab_b[0]  = '{1'b0, 1'b0, 4'b1100, 3'd0, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 4'b0000};
    tab_b[1]  = '{1'b1, 1'b0, 4'b1100, 3'd0, 1'b1, 1'b0, 1'b0, 4'd7, 1'b0, 4'b0001};
    tab_b[2]  = '{1'b1, 1'b0, 4'b1100, 3'd1, 1'b1, 1'b0, 1'b0, 4'd6, 1'b0, 4'b0011};

    // Asynchronous reset with the clock not yet running.
    #3 rst_n = 1'b0;
    #1 chk_reset("por");

    clk_en = 1'b1;
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_vec(tab_a[i], $sformatf("a%0d", i));
    end

    // Read every cycle while the writer stays full-ahead; rbin crosses 15 -> 0.
    for (int r = 4; r <= 16; r++) begin
      logic [3:0] rb;
      rb = 4'(r);
      w.rd_en     = 1'b1;
      w.clr       = 1'b0;
      w.wptr      = gray(rb + 4'd9);
      w.exp_addr  = rb[2:0];
      w.exp_mrd   = 1'b1;
      w.exp_empty = 1'b0;
      w.exp_ae    = 1'b0;
      w.exp_cnt   = 4'd8;
      w.exp_uf    = 1'b0;
      w.exp_gray  = gray(rb + 4'd1);
      run_vec(w, $sformatf("wrap%0d", r));
    end

    // Reset mid-operation, between edges, with a read pending.
    @(negedge CLK);
    #2;
    rd_en = 1'b1;
    rst_n = 1'b0;
    #1 chk_reset("mid");
    rd_en     = 1'b0;
    wptr_sync = 4'b0000;
    @(negedge CLK);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      run_vec(tab_b[i], $sformatf("b%0d", i));
    end

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 3, meaning the memory address width; FIFO depth is 2^ADDR_WIDTH and pointer width PW = ADDR_WIDTH+1.
REQ-002 The block SHALL have parameter AEMPTY_TH, default 1, meaning the occupancy at or below which almost_empty asserts.
REQ-003 The block SHALL have port CLK  input  1  read-domain clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port rd_en  input  1  consumer read request.
REQ-006 The block SHALL have port clr_err  input  1  synchronous clear of the underflow flag.
REQ-007 The block SHALL have port wptr_sync  input  PW  write pointer, Gray code, already synchronized into CLK domain.
REQ-008 The block SHALL have port rd_addr  output  ADDR_WIDTH  memory read address, binary.
REQ-009 The block SHALL have port mem_rd_en  output  1  memory read strobe.
REQ-010 The block SHALL have port rptr_gray  output  PW  registered read pointer, Gray code, for synchronization into the write domain.
REQ-011 The block SHALL have port empty  output  1  registered empty flag.
REQ-012 The block SHALL have port almost_empty  output  1  registered almost-empty flag.
REQ-013 The block SHALL have port rd_count  output  PW  registered occupancy, 0..2^ADDR_WIDTH.
REQ-014 The block SHALL have port underflow  output  1  sticky read-while-empty error.

Function
REQ-015 The block SHALL hold a PW-bit binary read pointer rbin; rd_fire = rd_en AND NOT empty.
REQ-016 The block SHALL compute rbin_next = rbin + rd_fire, modulo 2^PW (wraps from 2^PW-1 to 0, no saturation).
REQ-017 The block SHALL compute rgray_next = rbin_next XOR (rbin_next >> 1) and register it into rptr_gray each cycle; rptr_gray SHALL come only from a flop, never from logic.
REQ-018 rd_addr SHALL equal rbin[ADDR_WIDTH-1:0] combinationally from the register; mem_rd_en SHALL equal rd_fire combinationally.
REQ-019 The block SHALL register empty <= (rgray_next == wptr_sync), so a read of the last word asserts empty on the same edge that advances the pointer.
REQ-020 The block SHALL convert wptr_sync to binary wbin (bit i = XOR of Gray bits PW-1 down to i) and register rd_count <= (wbin - rbin_next) modulo 2^PW.
REQ-021 The block SHALL register almost_empty <= (next rd_count <= AEMPTY_TH).
REQ-022 rd_en while empty SHALL NOT move rbin, rptr_gray, rd_addr, or assert mem_rd_en, and SHALL set underflow on the next edge.
REQ-023 underflow SHALL remain set until clr_err is sampled high; if clr_err and a new underflow event occur in the same cycle, underflow SHALL stay 1.
REQ-024 A write pointer advancing while a read fires SHALL be handled in one cycle: count and flags reflect both, no lost update.
REQ-025 Latency: pointer/flag/count update one cycle after rd_en or wptr_sync change; no other pipeline stages.

Reset
REQ-026 On rst_n low, immediately and regardless of CLK: rbin=0, rptr_gray=0, rd_addr=0, empty=1, almost_empty=1, rd_count=0, underflow=0; mem_rd_en=0 because empty=1.
REQ-027 Reset asserted mid-operation SHALL discard all pointer state; after release the block SHALL behave as from power-up, with wptr_sync expected also reset to 0.

Verification (ADDR_WIDTH=3, AEMPTY_TH=1)
REQ-028 Reset: assert rst_n=0 without clock -> all outputs at REQ-026 values immediately.
REQ-029 Fill 3: wptr_sync=4'b0010 -> next edge empty=0, rd_count=3, almost_empty=0; three rd_en cycles -> rd_addr 0,1,2, mem_rd_en high each; rd_count 2,1,0; almost_empty=1 after second read; empty=1 after third.
REQ-030 Underflow: empty=1, rd_en=1 -> rd_addr stays, mem_rd_en=0, underflow=1 next edge; clr_err=1 one cycle -> underflow=0.
REQ-031 Full: rbin=0, wptr_sync=4'b1100 (binary 8) -> rd_count=8, empty=0.
REQ-032 Wrap: step rbin 15 -> 0 with wptr_sync ahead -> rptr_gray 4'b1000 -> 4'b0000, rd_addr 7 -> 0, rd_count correct across the wrap.
REQ-033 Simultaneous: rd_count=1, one read fires while wptr_sync advances by 1 -> rd_count stays 1, empty stays 0.
